// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_pkg
//  Description : Shared processor constants. Holds the sequencer state
//                encoding and the default sequential PC increment that the
//                branch increment logic also uses.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    // Sequencer state encoding
    localparam logic [1:0] c_STATE_BOOT  = 2'b00;
    localparam logic [1:0] c_STATE_FETCH = 2'b01;
    localparam logic [1:0] c_STATE_EXEC  = 2'b10;
    localparam logic [1:0] c_STATE_HALT  = 2'b11;

    // Word increment for a fall-through (non-branch, non-jump) instruction
    localparam int unsigned c_DEFAULT_INC = 1;

endpackage : pc_sequencer_pkg
`default_nettype wire

// File: rtl/pc_sequencer_next_pc_mux.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_mux
//  Description : Combinational next-PC select. Priority is jump, then
//                branch, then fall-through. All additions are modulo
//                2^WORDSIZE; a negative increment arrives in two's complement
//                so backward branches wrap without special handling.
//  Ports       : i_pc          - current program counter (word address)
//                i_branch_en   - use i_inc as the increment
//                i_inc         - signed word increment from branch logic
//                i_jump_en     - use i_jump_target as the next PC
//                i_jump_target - absolute next PC
//                o_next_pc     - selected next PC
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_mux
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned WORDSIZE = 64
) (
    input  logic [WORDSIZE-1:0] i_pc,
    input  logic                i_branch_en,
    input  logic [WORDSIZE-1:0] i_inc,
    input  logic                i_jump_en,
    input  logic [WORDSIZE-1:0] i_jump_target,
    output logic [WORDSIZE-1:0] o_next_pc
);

    localparam logic [WORDSIZE-1:0] c_INC_SEQ = WORDSIZE'(c_DEFAULT_INC);

    always_comb begin
        o_next_pc = i_pc + c_INC_SEQ;
        if (i_jump_en) begin
            o_next_pc = i_jump_target;
        end else if (i_branch_en) begin
            o_next_pc = i_pc + i_inc;
        end
    end

endmodule : next_pc_mux
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter register and fetch sequencer. Issues a fetch
//                at pc, waits for the datapath to resolve the instruction,
//                then commits the next PC (sequential, branch or jump),
//                pulses retire and bumps the retired-instruction counter.
//                A halting instruction parks the sequencer until reset.
//  Ports       : clk, rst_n    - clock, asynchronous active-low reset
//                fetch_ready   - memory accepts the fetch at pc
//                exec_done     - next-PC inputs are valid this cycle
//                branch_en/inc - conditional branch and its increment
//                jump_en/jump_target - absolute jump
//                halt_req      - stop after this commit
//                pc, fetch_valid, retire, halted, retired_count - registered
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned           WORDSIZE = 64,
    parameter logic [WORDSIZE-1:0]   RESET_PC = '0,
    parameter int unsigned           COUNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_ready,
    input  logic                exec_done,
    input  logic                branch_en,
    input  logic [WORDSIZE-1:0] inc,
    input  logic                jump_en,
    input  logic [WORDSIZE-1:0] jump_target,
    input  logic                halt_req,
    output logic [WORDSIZE-1:0] pc,
    output logic                fetch_valid,
    output logic                retire,
    output logic                halted,
    output logic [COUNT_W-1:0]  retired_count
);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [WORDSIZE-1:0] r_pc;
    logic [WORDSIZE-1:0] w_next_pc;
    logic                r_fetch_valid;
    logic                r_retire;
    logic                r_halted;
    logic [COUNT_W-1:0]  r_count;
    logic                w_commit;

    next_pc_mux #(
        .WORDSIZE (WORDSIZE)
    ) u_next_pc_mux (
        .i_pc          (r_pc),
        .i_branch_en   (branch_en),
        .i_inc         (inc),
        .i_jump_en     (jump_en),
        .i_jump_target (jump_target),
        .o_next_pc     (w_next_pc)
    );

    // Next-state logic. Inputs outside their owning state are simply not
    // looked at, which is what makes them "ignored".
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            c_STATE_BOOT: begin
                w_state_nxt = c_STATE_FETCH;
            end
            c_STATE_FETCH: begin
                if (r_fetch_valid && fetch_ready) begin
                    w_state_nxt = c_STATE_EXEC;
                end
            end
            c_STATE_EXEC: begin
                if (exec_done) begin
                    w_commit    = 1'b1;
                    w_state_nxt = halt_req ? c_STATE_HALT : c_STATE_FETCH;
                end
            end
            c_STATE_HALT: begin
                w_state_nxt = c_STATE_HALT;
            end
            default: begin
                w_state_nxt = c_STATE_BOOT;
            end
        endcase
    end

    // Status outputs are decoded from the next state so that they are
    // registered yet line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_STATE_BOOT;
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_retire      <= 1'b0;
            r_halted      <= 1'b0;
            r_count       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_valid <= (w_state_nxt == c_STATE_FETCH);
            r_halted      <= (w_state_nxt == c_STATE_HALT);
            r_retire      <= w_commit;
            if (w_commit) begin
                r_pc    <= w_next_pc;
                r_count <= r_count + COUNT_W'(1);
            end
        end
    end

    assign pc            = r_pc;
    assign fetch_valid   = r_fetch_valid;
    assign retire        = r_retire;
    assign halted        = r_halted;
    assign retired_count = r_count;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed bench for pc_sequencer. Each commit pushes its
//                hand-computed pc / count into a queue; a monitor pops and
//                compares whenever retire is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int unsigned c_W  = 64;
    localparam int unsigned c_CW = 32;

    logic            clk;
    logic            rst_n;
    logic            fetch_ready;
    logic            exec_done;
    logic            branch_en;
    logic [c_W-1:0]  inc;
    logic            jump_en;
    logic [c_W-1:0]  jump_target;
    logic            halt_req;
    logic [c_W-1:0]  pc;
    logic            fetch_valid;
    logic            retire;
    logic            halted;
    logic [c_CW-1:0] retired_count;

    typedef struct {
        logic [c_W-1:0]  pc;
        logic [c_CW-1:0] cnt;
    } exp_t;

    exp_t            exp_q[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    logic [c_CW-1:0] exp_count;

    pc_sequencer #(
        .WORDSIZE (c_W),
        .RESET_PC ('0),
        .COUNT_W  (c_CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_ready   (fetch_ready),
        .exec_done     (exec_done),
        .branch_en     (branch_en),
        .inc           (inc),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .halt_req      (halt_req),
        .pc            (pc),
        .fetch_valid   (fetch_valid),
        .retire        (retire),
        .halted        (halted),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [c_W-1:0] act,
                         input logic [c_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every retire pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && retire) begin
            if (exp_q.size() == 0) begin
                check("retire_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("commit_pc", pc, e.pc);
                check("commit_count", 64'(retired_count), 64'(e.cnt));
            end
        end
    end

    task automatic clear_inputs();
        fetch_ready = 1'b0;
        exec_done   = 1'b0;
        branch_en   = 1'b0;
        inc         = '0;
        jump_en     = 1'b0;
        jump_target = '0;
        halt_req    = 1'b0;
    endtask

    // Bounded wait for a pending fetch; called at a negedge
    task automatic wait_fetch();
        int n;
        n = 0;
        while (fetch_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (fetch_valid !== 1'b1) check("fetch_timeout", {63'd0, fetch_valid}, 64'd1);
    endtask

    // One full instruction: accept the fetch, then resolve it in EXEC
    task automatic run_instr(input logic br, input logic [c_W-1:0] inc_v,
                             input logic jmp, input logic [c_W-1:0] tgt,
                             input logic hlt, input logic [c_W-1:0] exp_pc);
        exp_t e;
        wait_fetch();
        fetch_ready = 1'b1;
        @(negedge clk);
        fetch_ready = 1'b0;
        branch_en   = br;
        inc         = inc_v;
        jump_en     = jmp;
        jump_target = tgt;
        halt_req    = hlt;
        exec_done   = 1'b1;
        exp_count   = exp_count + 1;
        e.pc  = exp_pc;
        e.cnt = exp_count;
        exp_q.push_back(e);
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        exp_count = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 64'd0);
        check("rst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        check("rst_retire", {63'd0, retire}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_count", 64'(retired_count), 64'd0);
        rst_n = 1'b1;
        #1 check("boot_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        @(negedge clk);
        check("post_boot_fetch_valid", {63'd0, fetch_valid}, 64'd1);
        check("post_boot_pc", pc, 64'd0);

        // Sequential run
        run_instr(0, '0, 0, '0, 0, 64'd1);
        run_instr(0, '0, 0, '0, 0, 64'd2);
        run_instr(0, '0, 0, '0, 0, 64'd3);
        check("seq_count", 64'(retired_count), 64'd3);

        // Backward branch and wrap
        run_instr(0, '0, 1, 64'd5, 0, 64'd5);
        run_instr(1, 64'hFFFF_FFFF_FFFF_FFFB, 0, '0, 0, 64'd0);
        run_instr(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, '0, 0, 64'hFFFF_FFFF_FFFF_FFFF);

        // Jump beats branch
        run_instr(0, '0, 1, 64'd2, 0, 64'd2);
        run_instr(1, 64'd8, 1, 64'h40, 0, 64'h40);

        // Backpressure, with a stray exec_done while still fetching
        wait_fetch();
        for (int i = 0; i < 4; i++) begin
            exec_done = (i == 1);
            @(negedge clk);
            check("bp_fetch_valid", {63'd0, fetch_valid}, 64'd1);
            check("bp_pc", pc, 64'h40);
        end
        exec_done = 1'b0;
        check("bp_count", 64'(retired_count), 64'd8);
        run_instr(0, '0, 0, '0, 0, 64'h41);

        // Halt
        run_instr(0, '0, 1, 64'd7, 0, 64'd7);
        run_instr(0, '0, 0, '0, 1, 64'd8);
        check("halt_halted", {63'd0, halted}, 64'd1);
        check("halt_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            exec_done   = 1'b1;
            fetch_ready = 1'b1;
            jump_en     = 1'b1;
            jump_target = 64'h99;
            @(negedge clk);
            check("halt_pc", pc, 64'd8);
            check("halt_hold", {63'd0, halted}, 64'd1);
        end
        clear_inputs();
        check("halt_count", 64'(retired_count), 64'd11);

        // Leave HALT via reset, then reset again in the middle of EXEC
        rst_n = 1'b0;
        exp_count = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wait_fetch();
        fetch_ready = 1'b1;
        @(negedge clk);
        fetch_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc, 64'd0);
        check("async_rst_count", 64'(retired_count), 64'd0);
        check("async_rst_halted", {63'd0, halted}, 64'd0);
        check("async_rst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_boot_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        @(negedge clk);
        check("rel_fetch_valid", {63'd0, fetch_valid}, 64'd1);
        run_instr(0, '0, 0, '0, 0, 64'd1);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
